// File: rtl/stride_rd_if.sv
// Read-address handshake bundle between the stride address generator and the line-buffer read port.
interface stride_rd_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic                  addr_ready;
  logic                  addr_last;

  modport master (output addr, output addr_valid, output addr_last, input addr_ready);
  modport slave  (input addr, input addr_valid, input addr_last, output addr_ready);
endinterface

// File: rtl/stride_read_addr_gen.sv
// Walks the strided line buffer back out column-then-offset: addr = j + i*STRIDE, i inner, j outer.
// The address is built by accumulation only, so no multiplier is needed.
module stride_read_addr_gen #(
  parameter int CNT_1      = 14,
  parameter int CNT_2      = 8,
  parameter int STRIDE     = 14,
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sel_i,
  stride_rd_if.master      rd,
  output logic             busy_o,
  output logic             done_o
);

  localparam int MAX_N = (CNT_1 > CNT_2) ? CNT_1 : CNT_2;
  localparam int I_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int J_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [I_W-1:0]        I_LAST_1 = I_W'(CNT_1 - 1);
  localparam logic [I_W-1:0]        I_LAST_2 = I_W'(CNT_2 - 1);
  localparam logic [J_W-1:0]        J_LAST   = J_W'(STRIDE - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRIDE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [I_W-1:0]        i_q, i_d;
  logic [J_W-1:0]        j_q, j_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] acc_q, acc_d;

  logic [I_W-1:0] i_last;
  logic           i_wrap;
  logic           j_wrap;

  assign i_last = sel_q ? I_LAST_2 : I_LAST_1;
  assign i_wrap = (i_q == i_last);
  assign j_wrap = (j_q == J_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      i_q     <= i_d;
      j_q     <= j_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    i_d     = i_q;
    j_d     = j_q;
    base_d  = base_q;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          sel_d   = sel_i;
          i_d     = '0;
          j_d     = '0;
          base_d  = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (rd.addr_ready) begin
          if (!i_wrap) begin
            i_d   = i_q + I_W'(1);
            acc_d = acc_q + STEP;
          end else if (!j_wrap) begin
            // next column starts at its own offset; base tracks j in address width
            i_d    = '0;
            j_d    = j_q + J_W'(1);
            base_d = base_q + ADDR_WIDTH'(1);
            acc_d  = base_q + ADDR_WIDTH'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd.addr_valid = (state_q == RUN);
  assign rd.addr       = (state_q == RUN) ? acc_q : '0;
  assign rd.addr_last  = (state_q == RUN) && i_wrap && j_wrap;
  assign busy_o        = (state_q == RUN);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_stride_read_addr_gen.sv
// Bench for stride_read_addr_gen: pass-level reference model checked every cycle, plus literal anchors.
module tb_stride_read_addr_gen;
  localparam int AW = 8;
  localparam int S  = 14;
  localparam int C1 = 14;
  localparam int C2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic ready = 1'b1;
  logic busy, done;

  always #5 clk = ~clk;

  stride_rd_if #(.ADDR_WIDTH(AW)) bus ();
  assign bus.addr_ready = ready;

  stride_read_addr_gen #(
    .CNT_1(C1), .CNT_2(C2), .STRIDE(S), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .sel_i(sel),
    .rd(bus.master), .busy_o(busy), .done_o(done)
  );

  int tests = 0;
  int fails = 0;
  int log_q[$];
  int done_cnt = 0;

  // reference model: a pass is just the list of addresses it must emit
  int  exp_q[$];
  bit  m_run  = 1'b0;
  bit  m_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_pass(input bit s);
    int n;
    n = s ? C2 : C1;
    exp_q.delete();
    for (int j = 0; j < S; j++)
      for (int i = 0; i < n; i++)
        exp_q.push_back(j + i * S);
  endtask

  always @(negedge clk) begin
    chk("valid", int'(bus.addr_valid), int'(m_run));
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    if (m_run) begin
      chk("addr", int'(bus.addr), exp_q[0]);
      chk("last", int'(bus.addr_last), int'(exp_q.size() == 1));
    end else begin
      chk("addr_idle", int'(bus.addr), 0);
      chk("last_idle", int'(bus.addr_last), 0);
    end
    if (!rst && bus.addr_valid && ready) log_q.push_back(int'(bus.addr));
    if (!rst && done) done_cnt++;

    if (rst) begin
      m_run = 1'b0; m_done = 1'b0; exp_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      if (ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_run = 1'b0; m_done = 1'b1;
        end
      end
    end else if (start) begin
      build_pass(sel);
      m_run = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input bit s, input bit rnd, input int budget);
    int d0;
    bit got;
    log_q.delete();
    d0 = done_cnt;
    got = 1'b0;
    sel = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
    end
    ready = 1'b1;
    if (!got) chk("pass_timeout", 0, 1);
    repeat (3) cyc();
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    bit hit;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // 1: reset mid-idle
    rst = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid", int'(bus.addr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(bus.addr), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // 2: sel=0 full throughput
    run_pass(1'b0, 1'b0, 400);
    chk("p0_len", log_q.size(), 196);
    chk("p0_a0", log_q[0], 0);
    chk("p0_a1", log_q[1], 14);
    chk("p0_a13", log_q[13], 182);
    chk("p0_a14", log_q[14], 1);
    chk("p0_a195", log_q[195], 195);

    // 3: sel=1 full throughput
    run_pass(1'b1, 1'b0, 400);
    chk("p1_len", log_q.size(), 112);
    chk("p1_a7", log_q[7], 98);
    chk("p1_a8", log_q[8], 1);
    chk("p1_a111", log_q[111], 111);

    // 4: sel=0 with random backpressure
    run_pass(1'b0, 1'b1, 2000);
    chk("p4_len", log_q.size(), 196);
    chk("p4_a195", log_q[195], 195);

    // 5: reset at beat 50 aborts without done
    log_q.delete();
    d0 = done_cnt;
    hit = 1'b0;
    sel = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (log_q.size() >= 50) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    chk("abort_reach50", int'(hit), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(bus.addr_valid), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (4) cyc();
    chk("abort_no_done", done_cnt - d0, 0);
    run_pass(1'b0, 1'b0, 400);
    chk("restart_a0", log_q[0], 0);
    chk("restart_len", log_q.size(), 196);

    // 6: start held high, sel toggled mid-pass
    log_q.delete();
    d0 = done_cnt;
    hit = 1'b0;
    sel = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (done_cnt - d0 >= 2) begin
        hit = 1'b1;
        break;
      end
      if (k % 37 == 20) sel = ~sel;
      cyc();
    end
    start = 1'b0;
    chk("held_two_passes", int'(hit), 1);
    chk("held_first_a8", log_q[8], 1);
    repeat (5) cyc();
    chk("held_done_total", done_cnt - d0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
